// File: rtl/alt_vipcti131_common_pkg.sv
// Shared definitions for the vipcti131 common blocks: transfer scheduler state
// encoding and a clog2 helper that never returns a zero width.
package alt_vipcti131_common_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitAck = 2'd1,
    StHoldoff = 2'd2
  } xfer_state_e;

  // Minimum of 1 so a select/counter port never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned MaxReq     = 8;
  localparam int unsigned MaxReqSelW = clog2_min1(MaxReq);

endpackage

// File: rtl/alt_vipcti131_common_sync.sv
// Common level synchroniser: two flops into sync_clock, or a plain wire when
// the source already lives in that clock domain.
module alt_vipcti131_common_sync #(
  parameter int unsigned CLOCKS_ARE_SAME = 0,
  parameter int unsigned WIDTH           = 1
) (
  input  logic             rst,
  input  logic             sync_clock,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (CLOCKS_ARE_SAME != 0) begin : g_bypass
    logic unused_ports;
    assign unused_ports = ^{rst, sync_clock};
    assign data_out     = data_in;
  end else begin : g_sync
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge sync_clock or posedge rst) begin
      if (rst) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= data_in;
        sync_q <= meta_q;
      end
    end

    assign data_out = sync_q;
  end

endmodule

// File: rtl/alt_vipcti131_common_xfer_sched.sv
// Round-robin scheduler that hands one requester's payload at a time to a far
// clock domain using a toggle request / toggle acknowledge handshake.
module alt_vipcti131_common_xfer_sched
  import alt_vipcti131_common_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned ACK_SAME_CLOCK = 0,
  parameter int unsigned TIMEOUT        = 1023,
  localparam int unsigned SelW          = clog2_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         xfer_data,
  output logic [SelW-1:0]          xfer_sel,
  output logic                     xfer_toggle,
  input  logic                     ack_toggle,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     clr_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? clog2_min1(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  xfer_state_e      state_q, state_d;
  logic [SelW-1:0]  last_grant_q;
  logic [SelW-1:0]  sel_q;
  logic [WIDTH-1:0] data_q;
  logic             tog_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             load;
  logic             ack_s;
  logic             grant_vld;
  logic [SelW-1:0]  grant_idx;
  logic [SelW-1:0]  idx;

  alt_vipcti131_common_sync #(
    .CLOCKS_ARE_SAME(ACK_SAME_CLOCK),
    .WIDTH          (1)
  ) u_ack_sync (
    .rst       (~rst_n),
    .sync_clock(clk),
    .data_in   (ack_toggle),
    .data_out  (ack_s)
  );

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = SelW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = StWaitAck;
          load    = 1'b1;
        end
      end
      StWaitAck: begin
        if (ack_s == tog_q) state_d = StHoldoff;
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (TIMEOUT != 0 && cnt_q == CntLast) err_set = 1'b1;
      end
      StHoldoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (load) cnt_d = '0;
    // A timeout landing in the same cycle as a clear must stay visible.
    err_d = err_set | (err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= SelW'(NUM_REQ - 1);
      sel_q        <= '0;
      data_q       <= '0;
      tog_q        <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (load) begin
        data_q       <= req_data[32'(grant_idx)*WIDTH +: WIDTH];
        sel_q        <= grant_idx;
        last_grant_q <= grant_idx;
        tog_q        <= ~tog_q;
      end
    end
  end

  // Gated by rst_n so the accept pulse also drops asynchronously.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == StIdle && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign xfer_data   = data_q;
  assign xfer_sel    = sel_q;
  assign xfer_toggle = tog_q;
  assign busy        = (state_q != StIdle);
  assign err_timeout = err_q;

endmodule
